// File: rtl/sync_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_pkg
// Shared definitions for sync_fifo and its read-side adapter.
//   DEFAULT_DATA_WIDTH : default word width of the FIFO and its adapters
//   ptr_inc()          : pointer increment that wraps at an arbitrary last
//                        index, so ring sizes need not be a power of two
// ---------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // Pointers are handled at 8 bits here; callers cast to their own width.
  function automatic logic [7:0] ptr_inc(input logic [7:0] ptr,
                                         input logic [7:0] last);
    if (ptr == last) begin
      return 8'd0;
    end else begin
      return ptr + 8'd1;
    end
  endfunction

endpackage

// File: rtl/sync_fifo_reader_buf.sv
// ---------------------------------------------------------------------------
// sync_fifo_reader_buf
// DEPTH-entry circular register buffer used to absorb the FIFO read latency.
// Ports:
//   clk, sclr            : clock, synchronous active-high reset
//   push, push_data      : write push_data at the tail
//   pop                  : drop the head entry (caller only pops when occ!=0)
//   occ                  : number of entries held (0..DEPTH)
//   head_data            : entry at the head pointer
// ---------------------------------------------------------------------------
module sync_fifo_reader_buf
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 3,
  localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  sclr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [OW-1:0]         occ,
  output logic [DATA_WIDTH-1:0] head_data
);

  localparam logic [7:0] LAST_IDX = 8'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]         head_r;
  logic [PW-1:0]         tail_r;
  logic [OW-1:0]         occ_r;

  // Storage, ring pointers and occupancy; push and pop may happen together.
  always_ff @(posedge clk) begin
    if (sclr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
      head_r <= {PW{1'b0}};
      tail_r <= {PW{1'b0}};
      occ_r  <= {OW{1'b0}};
    end else begin
      if (push) begin
        mem_r[tail_r] <= push_data;
        tail_r        <= PW'(ptr_inc(8'(tail_r), LAST_IDX));
      end
      if (pop) begin
        head_r <= PW'(ptr_inc(8'(head_r), LAST_IDX));
      end
      case ({push, pop})
        2'b10:   occ_r <= occ_r + OW'(1'b1);
        2'b01:   occ_r <= occ_r - OW'(1'b1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Head entry is read straight from the registers.
  always_comb begin
    occ       = occ_r;
    head_data = mem_r[head_r];
  end

endmodule

// File: rtl/sync_fifo_reader.sv
// ---------------------------------------------------------------------------
// sync_fifo_reader
// Read-side adapter for sync_fifo: issues FIFO reads on a credit basis and
// presents the returned words as a valid/ready stream with back-pressure.
// Ports:
//   clk, sclr         : clock, synchronous active-high reset (assert together
//                       with the FIFO's own reset)
//   fifo_empty        : FIFO empty flag (registered inside the FIFO)
//   fifo_dout         : FIFO data, valid the cycle after an accepted read
//   fifo_rd_en        : FIFO read request
//   m_valid/m_ready   : output stream handshake
//   m_data            : output word, zero while m_valid is low
//   idle              : nothing buffered, nothing in flight, FIFO empty
//   rd_count          : words delivered, wraps modulo 2^CNT_WIDTH
// BUF_DEPTH must be 2..8; 3 or more sustains one word per clock.
// ---------------------------------------------------------------------------
module sync_fifo_reader
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int BUF_DEPTH  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  sclr,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  idle,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam logic [OW:0] DEPTH_LIM = (OW + 1)'(BUF_DEPTH);

  logic                  pend_r;
  logic [CNT_WIDTH-1:0]  cnt_r;
  logic [OW-1:0]         occ_s;
  logic [DATA_WIDTH-1:0] head_s;
  logic [OW:0]           credit_s;
  logic                  pop_s;

  sync_fifo_reader_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .sclr      (sclr),
    .push      (pend_r),
    .push_data (fifo_dout),
    .pop       (pop_s),
    .occ       (occ_s),
    .head_data (head_s)
  );

  // Credit and stream outputs. The read request only looks at registered
  // occupancy plus the in-flight read, so m_ready never reaches fifo_rd_en
  // and a returning word always finds a free slot.
  always_comb begin
    credit_s   = {1'b0, occ_s} + {{OW{1'b0}}, pend_r};
    fifo_rd_en = !sclr && !fifo_empty && (credit_s < DEPTH_LIM);
    m_valid    = (occ_s != {OW{1'b0}});
    if (m_valid) begin
      m_data = head_s;
    end else begin
      m_data = {DATA_WIDTH{1'b0}};
    end
    pop_s    = m_valid && m_ready;
    idle     = (occ_s == {OW{1'b0}}) && !pend_r && fifo_empty;
    rd_count = cnt_r;
  end

  // In-flight read flag and delivered-word counter.
  always_ff @(posedge clk) begin
    if (sclr) begin
      pend_r <= 1'b0;
      cnt_r  <= {CNT_WIDTH{1'b0}};
    end else begin
      pend_r <= fifo_rd_en;
      if (pop_s) begin
        cnt_r <= cnt_r + CNT_WIDTH'(1'b1);
      end
    end
  end

endmodule
